grad_window_seq: RTL and testbench

//  Frame sequencer for the 3x3 gradient line-buffer window generator (two WIDTH-deep shift RAMs + 3x3 regs).

---
 rtl/grad_window_seq.sv | 163 ++++++++++++++++
 tb/tb_grad_window_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/grad_window_seq.sv
// Frame sequencer for the 3x3 gradient window generator: accepts the pixel stream,
// drives the line-buffer shift, tags interior windows and zero-flushes the buffers between frames.
module grad_window_seq #(
    parameter int WIDTH    = 510,
    parameter int DEPTH    = 638,
    parameter int PIPE_LAT = 3,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          pad_zero,
    output logic          win_valid,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done,
    output logic          err_overlap
);

    localparam int FLUSH_LEN = 2 * WIDTH + 3;
    localparam int PHASE_MAX = (FLUSH_LEN > PIPE_LAT) ? FLUSH_LEN : PIPE_LAT;
    localparam int PW        = $clog2(PHASE_MAX + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] TWO        = CW'(2);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [PW-1:0] DRAIN_LAST = PW'(PIPE_LAT - 1);
    localparam logic [PW-1:0] FLUSH_LAST = PW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [PW-1:0] phase_reg;
    logic          frame_done_reg;
    logic          err_overlap_reg;

    logic          accept;
    logic          interior;

    assign in_ready    = (state_reg == RUN);
    assign accept      = in_ready & in_valid;
    assign shift_en    = accept | (state_reg == FLUSH);
    assign pad_zero    = (state_reg == FLUSH);
    assign busy        = (state_reg != IDLE);
    assign frame_done  = frame_done_reg;
    assign err_overlap = err_overlap_reg;

    // A pixel at (r,c) completes the window centred on (r-1,c-1) once both are >= 2.
    assign interior = accept & (row_reg >= TWO) & (col_reg >= TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            row_reg         <= '0;
            col_reg         <= '0;
            phase_reg       <= '0;
            frame_done_reg  <= 1'b0;
            err_overlap_reg <= 1'b0;
        end else begin
            frame_done_reg  <= 1'b0;
            err_overlap_reg <= frame_start & (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        state_reg <= RUN;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        phase_reg <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (col_reg == COL_LAST) begin
                            col_reg <= '0;
                            if (row_reg == ROW_LAST) begin
                                row_reg   <= '0;
                                phase_reg <= '0;
                                state_reg <= DRAIN;
                            end else begin
                                row_reg <= row_reg + ONE;
                            end
                        end else begin
                            col_reg <= col_reg + ONE;
                        end
                    end
                end
                DRAIN: begin
                    // Let the final interior window leave the tag pipe before zero-flushing.
                    if (phase_reg == DRAIN_LAST) begin
                        phase_reg <= '0;
                        state_reg <= FLUSH;
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end
                FLUSH: begin
                    if (phase_reg == FLUSH_LAST) begin
                        phase_reg      <= '0;
                        state_reg      <= IDLE;
                        frame_done_reg <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag pipe, advanced every cycle; row/col only follow valid tags so the outputs hold.
    logic          pipe_vld_reg [PIPE_LAT];
    logic [CW-1:0] pipe_row_reg [PIPE_LAT];
    logic [CW-1:0] pipe_col_reg [PIPE_LAT];
    logic          src_vld      [PIPE_LAT];
    logic [CW-1:0] src_row      [PIPE_LAT];
    logic [CW-1:0] src_col      [PIPE_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign src_vld[gi] = interior;
                assign src_row[gi] = row_reg - ONE;
                assign src_col[gi] = col_reg - ONE;
            end else begin : g_body
                assign src_vld[gi] = pipe_vld_reg[gi-1];
                assign src_row[gi] = pipe_row_reg[gi-1];
                assign src_col[gi] = pipe_col_reg[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_vld_reg[gi] <= 1'b0;
                    pipe_row_reg[gi] <= '0;
                    pipe_col_reg[gi] <= '0;
                end else begin
                    pipe_vld_reg[gi] <= src_vld[gi];
                    if (src_vld[gi]) begin
                        pipe_row_reg[gi] <= src_row[gi];
                        pipe_col_reg[gi] <= src_col[gi];
                    end
                end
            end
        end
    endgenerate

    assign win_valid = pipe_vld_reg[PIPE_LAT-1];
    assign win_row   = pipe_row_reg[PIPE_LAT-1];
    assign win_col   = pipe_col_reg[PIPE_LAT-1];

endmodule

// File: tb/tb_grad_window_seq.sv
// Directed/randomized bench for grad_window_seq: frame stimulus checked each cycle
// against a window schedule derived from pixel coordinates.
module tb_grad_window_seq;

    localparam int W  = 6;
    localparam int D  = 5;
    localparam int L  = 3;
    localparam int CW = 10;
    localparam int FLEN = 2 * W + 3;
    localparam int N_WIN = (W - 2) * (D - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic          pad_zero;
    logic          win_valid;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          busy;
    logic          frame_done;
    logic          err_overlap;

    grad_window_seq #(.WIDTH(W), .DEPTH(D), .PIPE_LAT(L), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
        .in_ready(in_ready), .shift_en(shift_en), .pad_zero(pad_zero),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .busy(busy), .frame_done(frame_done), .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int t; int r; int c;} win_t;
    win_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int exp_row  = 0;
    int exp_col  = 0;
    bit exp_ready, exp_shift, exp_pad, exp_done, tb_busy, fs_prev;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    // One clock: compare outputs mid-cycle, then move past the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
            check("win_valid", int'(win_valid), 1);
            exp_row = exp_q[0].r;
            exp_col = exp_q[0].c;
            void'(exp_q.pop_front());
            pulses++;
        end else begin
            check("win_valid", int'(win_valid), 0);
        end
        check("win_row", int'(win_row), exp_row);
        check("win_col", int'(win_col), exp_col);
        check("in_ready", int'(in_ready), int'(exp_ready));
        check("shift_en", int'(shift_en), int'(exp_shift));
        check("pad_zero", int'(pad_zero), int'(exp_pad));
        check("frame_done", int'(frame_done), int'(exp_done));
        check("busy", int'(busy), int'(tb_busy));
        check("err_overlap", int'(err_overlap), int'(fs_prev));
        $display("cyc=%0d fs=%0b iv=%0b rdy=%0b sh=%0b pz=%0b wv=%0b r=%0d c=%0d busy=%0b done=%0b err=%0b",
                 cyc, frame_start, in_valid, in_ready, shift_en, pad_zero, win_valid,
                 win_row, win_col, busy, frame_done, err_overlap);
        fs_prev = frame_start & tb_busy & rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_ready = 0; exp_shift = 0; exp_pad = 0; exp_done = 0; tb_busy = 0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        in_valid    = 1'b1;   // must not be taken in the arming cycle
        set_idle_exp();
        pulses = 0;
        tick();
        frame_start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: alternate 1/0, 2: random bubbles.
    // Returns 1 if the frame was cut short by a reset.
    task automatic run_frame(input int mode, input int ovl_at, input int rst_at, output bit aborted);
        int n = 0;
        int guard = 0;
        bit tog = 1'b1;
        bit ovl_done = 1'b0;
        bit v;
        aborted = 1'b0;
        while (n < W * D && guard < 2000) begin
            guard++;
            if (n == rst_at) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                frame_start = 1'b0;
                set_idle_exp();
                fs_prev = 1'b0;
                exp_q.delete();
                exp_row = 0;
                exp_col = 0;
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                aborted = 1'b1;
                return;
            end
            case (mode)
                0: v = 1'b1;
                1: v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            frame_start = (n == ovl_at) && !ovl_done;
            if (frame_start) ovl_done = 1'b1;
            in_valid  = v;
            exp_ready = 1; exp_shift = v; exp_pad = 0; exp_done = 0; tb_busy = 1;
            if (v) begin
                if (n / W >= 2 && n % W >= 2)
                    exp_q.push_back('{t: cyc + L, r: n / W - 1, c: n % W - 1});
                n++;
            end
            tick();
            frame_start = 1'b0;
        end
        check("run_guard", n, W * D);

        for (int i = 0; i < L; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            exp_ready = 0; exp_shift = 0; exp_pad = 0; exp_done = 0; tb_busy = 1;
            tick();
        end
        for (int i = 0; i < FLEN; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            exp_ready = 0; exp_shift = 1; exp_pad = 1; exp_done = 0; tb_busy = 1;
            tick();
        end
        in_valid = 1'b0;
        set_idle_exp();
        exp_done = 1;
        tick();
        exp_done = 0;
        tick();
        check("pulse_count", pulses, N_WIN);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit ab;
        set_idle_exp();
        fs_prev = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        start_frame(); run_frame(0, -1, -1, ab);
        start_frame(); run_frame(1, -1, -1, ab);
        start_frame(); run_frame(2, 10, -1, ab);
        start_frame(); run_frame(2, -1, 17, ab);
        check("mid_reset_abort", int'(ab), 1);
        start_frame(); run_frame(0, -1, -1, ab);
        start_frame(); run_frame(2, $urandom_range(0, 29), -1, ab);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
